// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter
// Brief    : Two-requester arbiter for the shared instruction/data memory;
//            one access in flight, sequenced over a fixed read latency.
// Revision : 1.0 - initial release
// ============================================================================
module mem_arbiter #(
    parameter int AW         = 10,
    parameter int READ_LAT   = 1,
    parameter int FIXED_PRIO = 0
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req0,
    input  logic          req1,
    input  logic          we0,
    input  logic          we1,
    input  logic [AW-1:0] addr0,
    input  logic [AW-1:0] addr1,
    input  logic [31:0]   wdata0,
    input  logic [31:0]   wdata1,
    input  logic [3:0]    wmask0,
    input  logic [3:0]    wmask1,
    output logic          gnt0,
    output logic          gnt1,
    output logic          done0,
    output logic          done1,
    output logic [31:0]   rdata0,
    output logic [31:0]   rdata1,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [31:0]   mem_wdata,
    output logic [3:0]    mem_wmask,
    input  logic [31:0]   mem_rdata,
    output logic          busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [1:0] c_cnt_init = 2'(READ_LAT - 1);

    state_t     r_state;
    state_t     w_next;
    logic [1:0] r_cnt;
    logic       r_last_gnt;
    logic       r_win;
    logic       r_we;

    logic       w_win;
    logic       w_grant;
    logic       w_sel_we;

    // Ties go to the requester that was not served last unless priority is fixed.
    assign w_win    = (req0 && req1) ? ((FIXED_PRIO != 0) ? 1'b0 : ~r_last_gnt) : req1;
    assign w_grant  = (r_state == IDLE) && !reset && (req0 || req1);
    assign w_sel_we = w_win ? we1 : we0;
    assign busy     = (r_state != IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= IDLE;
            r_cnt      <= 2'd0;
            r_last_gnt <= 1'b1;
            r_win      <= 1'b0;
            r_we       <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_grant) begin
                r_win      <= w_win;
                r_last_gnt <= w_win;
                r_we       <= w_sel_we;
                r_cnt      <= c_cnt_init;
            end else if (r_state == WAIT) begin
                r_cnt <= r_cnt - 2'd1;
            end
        end
    end

    always_comb begin
        w_next    = r_state;
        gnt0      = 1'b0;
        gnt1      = 1'b0;
        done0     = 1'b0;
        done1     = 1'b0;
        rdata0    = 32'd0;
        rdata1    = 32'd0;
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = 32'd0;
        mem_wmask = 4'd0;
        case (r_state)
            IDLE: begin
                if (w_grant) begin
                    w_next    = (READ_LAT == 1) ? RESP : WAIT;
                    gnt0      = ~w_win;
                    gnt1      = w_win;
                    mem_en    = 1'b1;
                    mem_we    = w_sel_we;
                    mem_addr  = w_win ? addr1 : addr0;
                    mem_wdata = w_win ? wdata1 : wdata0;
                    mem_wmask = w_win ? wmask1 : wmask0;
                end
            end
            WAIT: begin
                if (r_cnt == 2'd1) begin
                    w_next = RESP;
                end
            end
            RESP: begin
                w_next = IDLE;
                done0  = ~r_win;
                done1  = r_win;
                if (!r_we) begin
                    rdata0 = r_win ? 32'd0 : mem_rdata;
                    rdata1 = r_win ? mem_rdata : 32'd0;
                end
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

endmodule
`default_nettype wire
